// File: rtl/view_vertex_transform.sv
// 4x4 signed fixed-point matrix times vertex (implicit w = 1); one output row per cycle.
// Build option VIEW_VERTEX_TRANSFORM_SAT_EN clamps out-of-range rows, otherwise they wrap.
module view_vertex_transform #(
    parameter int WI  = 8,
    parameter int WF  = 8,
    parameter int WOI = 8,
    parameter int WOF = 8
) (
    input  logic                       Clk,
    input  logic                       Reset_n,
    input  logic [15:0][WI+WF-1:0]     view_matrix,
    input  logic [WI+WF-1:0]           in_x,
    input  logic [WI+WF-1:0]           in_y,
    input  logic [WI+WF-1:0]           in_z,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [WOI+WOF-1:0]         out_x,
    output logic [WOI+WOF-1:0]         out_y,
    output logic [WOI+WOF-1:0]         out_z,
    output logic [WOI+WOF-1:0]         out_w,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       overflow
);
    localparam int W   = WI + WF;
    localparam int WO  = WOI + WOF;
    localparam int PW  = 2 * W;
    localparam int SW  = PW + 2;
    localparam int SH  = 2 * WF - WOF;
    localparam int SHA = (SH < 0) ? -SH : SH;
    localparam int XW  = SW + 1 + SHA;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [WO-1:0] OUT_MAX = {1'b0, {(WO-1){1'b1}}};
    localparam logic [WO-1:0] OUT_MIN = {1'b1, {(WO-1){1'b0}}};

    // Full-width signed product of two W-bit entries.
    function automatic logic signed [PW-1:0] smul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [PW-1:0] ea;
        logic signed [PW-1:0] eb;
        ea = $signed({{W{a[W-1]}}, a});
        eb = $signed({{W{b[W-1]}}, b});
        return ea * eb;
    endfunction

    // True when the value is representable in WO signed bits.
    function automatic logic fits(input logic [XW-1:0] v);
        logic [XW-WO:0] top;
        top = v[XW-1:WO-1];
        return (&top) | ~(|top);
    endfunction

    logic [1:0]             r_state;
    logic [1:0]             r_row;
    logic [15:0][W-1:0]     r_m;
    logic [W-1:0]           r_x;
    logic [W-1:0]           r_y;
    logic [W-1:0]           r_z;
    logic [WO-1:0]          r_out_x;
    logic [WO-1:0]          r_out_y;
    logic [WO-1:0]          r_out_z;
    logic [WO-1:0]          r_out_w;
    logic                   r_out_valid;
    logic                   r_overflow;
    logic                   r_in_ready;

    logic [W-1:0]           w_m0;
    logic [W-1:0]           w_m1;
    logic [W-1:0]           w_m2;
    logic [W-1:0]           w_m3;
    logic signed [PW-1:0]   w_p0;
    logic signed [PW-1:0]   w_p1;
    logic signed [PW-1:0]   w_p2;
    logic signed [PW-1:0]   w_p3;
    logic signed [SW-1:0]   w_sum;
    logic signed [XW-1:0]   w_ext;
    logic signed [XW-1:0]   w_scaled;
    logic                   w_fit;
    logic [WO-1:0]          w_res;

    assign w_m0 = r_m[{r_row, 2'b00}];
    assign w_m1 = r_m[{r_row, 2'b01}];
    assign w_m2 = r_m[{r_row, 2'b10}];
    assign w_m3 = r_m[{r_row, 2'b11}];

    assign w_p0 = smul(w_m0, r_x);
    assign w_p1 = smul(w_m1, r_y);
    assign w_p2 = smul(w_m2, r_z);
    // Constant 1.0 at product scale is the entry shifted up by WF.
    assign w_p3 = $signed({{WI{w_m3[W-1]}}, w_m3, {WF{1'b0}}});

    assign w_sum = $signed({{2{w_p0[PW-1]}}, w_p0}) + $signed({{2{w_p1[PW-1]}}, w_p1})
                 + $signed({{2{w_p2[PW-1]}}, w_p2}) + $signed({{2{w_p3[PW-1]}}, w_p3});

    assign w_ext = $signed({{(XW-SW){w_sum[SW-1]}}, w_sum});

    generate
        if (SH > 0) begin : g_round
            localparam logic signed [XW-1:0] RND = {{(XW-1){1'b0}}, 1'b1} << (SH - 1);
            logic signed [XW-1:0] w_biased;
            assign w_biased = w_ext + RND;
            assign w_scaled = w_biased >>> SH;
        end else begin : g_shl
            assign w_scaled = w_ext <<< SHA;
        end
    endgenerate

    assign w_fit = fits(w_scaled);

    // Out-of-range handling: clamp or keep the low bits.
    always_comb begin
        w_res = w_scaled[WO-1:0];
`ifdef VIEW_VERTEX_TRANSFORM_SAT_EN
        if (!w_fit) begin
            if (w_scaled[XW-1]) begin
                w_res = OUT_MIN;
            end else begin
                w_res = OUT_MAX;
            end
        end else begin
            w_res = w_scaled[WO-1:0];
        end
`endif
    end

    // Control FSM, operand snapshot and row result registers.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_state     <= S_IDLE;
            r_row       <= 2'd0;
            r_m         <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_z         <= '0;
            r_out_x     <= '0;
            r_out_y     <= '0;
            r_out_z     <= '0;
            r_out_w     <= '0;
            r_out_valid <= 1'b0;
            r_overflow  <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_m        <= view_matrix;
                        r_x        <= in_x;
                        r_y        <= in_y;
                        r_z        <= in_z;
                        r_row      <= 2'd0;
                        r_overflow <= 1'b0;
                        r_in_ready <= 1'b0;
                        r_state    <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (!w_fit) begin
                        r_overflow <= 1'b1;
                    end
                    r_row <= r_row + 2'd1;
                    case (r_row)
                        2'd0: r_out_x <= w_res;
                        2'd1: r_out_y <= w_res;
                        2'd2: r_out_z <= w_res;
                        2'd3: begin
                            r_out_w     <= w_res;
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end
                        default: r_state <= S_IDLE;
                    endcase
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_x     = r_out_x;
    assign out_y     = r_out_y;
    assign out_z     = r_out_z;
    assign out_w     = r_out_w;
    assign out_valid = r_out_valid;
    assign overflow  = r_overflow;

endmodule
